// File: rtl/frame_rw_arbiter.sv
// Camera-write / HDMI-read burst arbiter over one frame buffer memory port.
// Define FRAME_PINGPONG_EN for two-bank ping-pong; otherwise a single bank is used.
module frame_rw_arbiter #(
    parameter int unsigned BURST_LEN     = 64,
    parameter int unsigned FRAME_WORDS   = 786432,
    parameter logic [23:0] BANK_STRIDE   = 24'h100000,
    parameter int unsigned RD_FIFO_DEPTH = 512,
    parameter int unsigned RD_LOW        = 128
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [9:0]  wr_fifo_cnt,
    input  logic [9:0]  rd_fifo_cnt,
    input  logic        wr_frame_start,
    input  logic        rd_frame_start,
    output logic        mem_req,
    output logic        mem_we,
    output logic [23:0] mem_addr,
    input  logic        mem_ack,
    input  logic        mem_done,
    output logic        wr_bank,
    output logic        rd_bank,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, CMD, WAIT} state_t;

    localparam logic [23:0] BURST  = 24'(BURST_LEN);
    localparam logic [23:0] FRAME  = 24'(FRAME_WORDS);
    localparam logic [10:0] WR_MIN = 11'(BURST_LEN);
    localparam logic [10:0] RD_MAX = 11'(RD_FIFO_DEPTH - BURST_LEN);
    localparam logic [10:0] RD_URG = 11'(RD_LOW);

    state_t      state;
    state_t      state_nxt;
    logic [23:0] wr_off;
    logic [23:0] rd_off;
    logic        wr_cmp;
    logic        rd_cmp;
    logic        wr_pend;
    logic        rd_pend;
    logic        last_rd;
    logic        apply;
    logic        wr_elig;
    logic        rd_elig;
    logic        rd_urgent;
    logic        grant;
    logic        grant_rd;
    logic [23:0] grant_base;
    logic [23:0] grant_addr;

    // Pending frame starts are serviced before any new burst is granted
    assign apply     = (state == IDLE) && (wr_pend || rd_pend);
    assign wr_elig   = ({1'b0, wr_fifo_cnt} >= WR_MIN) && !wr_cmp;
    assign rd_elig   = ({1'b0, rd_fifo_cnt} <= RD_MAX) && !rd_cmp;
    assign rd_urgent = rd_elig && ({1'b0, rd_fifo_cnt} < RD_URG);

    assign mem_req = (state == CMD);
    assign busy    = (state != IDLE);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        grant_rd  = 1'b0;
        case (state)
            IDLE: begin
                if (!apply) begin
                    if (rd_urgent) begin
                        grant    = 1'b1;
                        grant_rd = 1'b1;
                    end else if (wr_elig && rd_elig) begin
                        grant    = 1'b1;
                        grant_rd = !last_rd;
                    end else if (wr_elig || rd_elig) begin
                        grant    = 1'b1;
                        grant_rd = rd_elig;
                    end
                end
                if (grant) state_nxt = CMD;
            end
            CMD:     if (mem_ack) state_nxt = WAIT;
            WAIT:    if (mem_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef FRAME_PINGPONG_EN
    logic wr_bank_q;
    logic rd_bank_q;
    logic last_done_bank;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_bank_q      <= 1'b0;
            rd_bank_q      <= 1'b0;
            last_done_bank <= 1'b1;
        end else begin
            if (apply && wr_pend && wr_cmp) begin
                last_done_bank <= wr_bank_q;
                wr_bank_q      <= ~wr_bank_q;
            end
            if (apply && rd_pend) rd_bank_q <= last_done_bank;
        end
    end

    assign wr_bank    = wr_bank_q;
    assign rd_bank    = rd_bank_q;
    assign grant_base = (grant_rd ? rd_bank_q : wr_bank_q) ? BANK_STRIDE : 24'd0;
`else
    assign wr_bank    = 1'b0;
    assign rd_bank    = 1'b0;
    assign grant_base = 24'd0;
`endif

    assign grant_addr = grant_base + (grant_rd ? rd_off : wr_off);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            mem_we   <= 1'b0;
            mem_addr <= 24'd0;
            wr_off   <= 24'd0;
            rd_off   <= 24'd0;
            wr_cmp   <= 1'b0;
            rd_cmp   <= 1'b0;
            wr_pend  <= 1'b0;
            rd_pend  <= 1'b0;
            last_rd  <= 1'b1;
        end else begin
            wr_pend <= wr_frame_start | (wr_pend & ~apply);
            rd_pend <= rd_frame_start | (rd_pend & ~apply);
            if (grant) begin
                mem_we   <= !grant_rd;
                mem_addr <= grant_addr;
                last_rd  <= grant_rd;
            end
            // Offset advances only once the burst has actually finished
            if (state == WAIT && mem_done) begin
                if (mem_we) begin
                    wr_off <= wr_off + BURST;
                    if (wr_off + BURST == FRAME) wr_cmp <= 1'b1;
                end else begin
                    rd_off <= rd_off + BURST;
                    if (rd_off + BURST == FRAME) rd_cmp <= 1'b1;
                end
            end
            if (apply && wr_pend) begin
                wr_off <= 24'd0;
                wr_cmp <= 1'b0;
            end
            if (apply && rd_pend) begin
                rd_off <= 24'd0;
                rd_cmp <= 1'b0;
            end
        end
    end

endmodule
